control_sequencer: RTL

//  Registered successor of the combinational opcode decoder. Accepts one opcode per
//  in_valid/in_ready handshake and drives the ID/EX control register one cycle later.

---
 rtl/control_sequencer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// Registered opcode decoder/sequencer: drives the ID/EX control register one cycle after
// accept and expands CALL/RET/INT/RTI into stack push/pop micro-op sequences.
module control_sequencer #(
  parameter int OPCODE_W   = 5,
  parameter int ALU_SEL_W  = 4,
  parameter int SAVE_FLAGS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OPCODE_W-1:0]  opcode,
  input  logic                 stall,
  input  logic                 flush,
  output logic                 out_valid,
  output logic [9:0]           ctrl,
  output logic [ALU_SEL_W-1:0] aluSignals,
  output logic [1:0]           sp_op,
  output logic [1:0]           mem_src,
  output logic [1:0]           pc_sel,
  output logic                 flags_load,
  output logic                 illegal,
  output logic                 busy
);

  localparam logic [OPCODE_W-1:0] OP_NOP  = 'd0,  OP_ADD  = 'd1,  OP_SUB  = 'd2,  OP_AND = 'd3,
                                  OP_OR   = 'd4,  OP_NOT  = 'd5,  OP_INC  = 'd6,  OP_DEC = 'd7,
                                  OP_MOV  = 'd8,  OP_PUSH = 'd9,  OP_POP  = 'd10, OP_LDM = 'd11,
                                  OP_JZ   = 'd12, OP_JN   = 'd13, OP_JC   = 'd14, OP_JMP = 'd15,
                                  OP_SETC = 'd16, OP_CLRC = 'd17, OP_IN   = 'd18, OP_OUT = 'd19,
                                  OP_CALL = 'd20, OP_RET  = 'd21, OP_INT  = 'd22, OP_RTI = 'd23;

  localparam logic [ALU_SEL_W-1:0] ALU_NOP = 'd0, ALU_ADD = 'd1, ALU_SUB = 'd2, ALU_AND = 'd3,
                                   ALU_OR  = 'd4, ALU_NOT = 'd5, ALU_INC = 'd6, ALU_DEC = 'd7,
                                   ALU_MOV = 'd8;

  // ctrl = {IR,IW,MR,MW,MTR,ALU_src,RW,Branch,SetC,CLRC}
  localparam logic [9:0] C_NONE = 10'h000, C_IR  = 10'h200, C_IW  = 10'h100, C_MR   = 10'h080,
                         C_MW   = 10'h040, C_MTR = 10'h020, C_SRC = 10'h010, C_RW   = 10'h008,
                         C_BR   = 10'h004, C_SETC = 10'h002, C_CLRC = 10'h001;

  localparam logic [1:0] SP_NONE = 2'b00, SP_POP = 2'b01, SP_PUSH = 2'b10;
  localparam logic [1:0] MS_RSRC = 2'b00, MS_PC  = 2'b01, MS_FLAGS = 2'b10;
  localparam logic [1:0] PC_INC  = 2'b00, PC_REG = 2'b01, PC_MEM = 2'b10, PC_VEC = 2'b11;

  localparam logic [1:0] IDLE = 2'd0, S1 = 2'd1, S2 = 2'd2;
  localparam logic [1:0] K_CALL = 2'd0, K_RET = 2'd1, K_INT = 2'd2, K_RTI = 2'd3;

  localparam logic SF = (SAVE_FLAGS != 0);

  typedef struct packed {
    logic                 vld;
    logic [9:0]           ctrl;
    logic [ALU_SEL_W-1:0] alu;
    logic [1:0]           sp_op;
    logic [1:0]           mem_src;
    logic [1:0]           pc_sel;
    logic                 flags_load;
  } uop_t;

  function automatic uop_t nop_uop();
    uop_t u;
    u     = '0;
    u.alu = ALU_NOP;
    return u;
  endfunction

  function automatic uop_t mk(logic [9:0] c, logic [ALU_SEL_W-1:0] a, logic [1:0] sp,
                              logic [1:0] ms, logic [1:0] pc, logic fl);
    uop_t u;
    u.vld        = 1'b1;
    u.ctrl       = c;
    u.alu        = a;
    u.sp_op      = sp;
    u.mem_src    = ms;
    u.pc_sel     = pc;
    u.flags_load = fl;
    return u;
  endfunction

  function automatic logic [ALU_SEL_W-1:0] alu_of(logic [OPCODE_W-1:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_NOT:  return ALU_NOT;
      OP_INC:  return ALU_INC;
      OP_DEC:  return ALU_DEC;
      default: return ALU_MOV;
    endcase
  endfunction

  logic [1:0] state_q, state_d, kind_q, kind_d;
  uop_t       uop_q, uop_d;
  logic       ill_q, ill_d;

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    uop_d   = uop_q;
    ill_d   = ill_q;
    if (flush) begin
      state_d = IDLE;
      uop_d   = nop_uop();
      ill_d   = 1'b0;
    end else if (!stall) begin
      uop_d = nop_uop();
      ill_d = 1'b0;
      case (state_q)
        IDLE: if (in_valid) begin
          case (opcode)
            OP_NOP:  uop_d = mk(C_NONE, ALU_NOP, SP_NONE, MS_RSRC, PC_INC, 1'b0);
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_INC, OP_DEC, OP_MOV:
                     uop_d = mk(C_RW, alu_of(opcode), SP_NONE, MS_RSRC, PC_INC, 1'b0);
            OP_PUSH: uop_d = mk(C_MW, ALU_NOP, SP_PUSH, MS_RSRC, PC_INC, 1'b0);
            OP_POP:  uop_d = mk(C_MR | C_MTR | C_RW, ALU_NOP, SP_POP, MS_RSRC, PC_INC, 1'b0);
            OP_LDM:  uop_d = mk(C_SRC | C_RW, ALU_MOV, SP_NONE, MS_RSRC, PC_INC, 1'b0);
            OP_JZ, OP_JN, OP_JC, OP_JMP:
                     uop_d = mk(C_BR, ALU_NOP, SP_NONE, MS_RSRC, PC_REG, 1'b0);
            OP_SETC: uop_d = mk(C_SETC, ALU_NOP, SP_NONE, MS_RSRC, PC_INC, 1'b0);
            OP_CLRC: uop_d = mk(C_CLRC, ALU_NOP, SP_NONE, MS_RSRC, PC_INC, 1'b0);
            OP_IN:   uop_d = mk(C_IR | C_RW, ALU_NOP, SP_NONE, MS_RSRC, PC_INC, 1'b0);
            OP_OUT:  uop_d = mk(C_IW, ALU_NOP, SP_NONE, MS_RSRC, PC_INC, 1'b0);
            OP_CALL, OP_INT: begin
              uop_d   = mk(C_MW, ALU_NOP, SP_PUSH, MS_PC, PC_INC, 1'b0);
              state_d = S1;
              kind_d  = (opcode == OP_CALL) ? K_CALL : K_INT;
            end
            OP_RET, OP_RTI: begin
              // RTI pops flags first since INT pushed them last
              uop_d   = mk(C_MR, ALU_NOP, SP_POP, MS_RSRC, PC_INC, (opcode == OP_RTI) & SF);
              state_d = S1;
              kind_d  = (opcode == OP_RET) ? K_RET : K_RTI;
            end
            default: ill_d = 1'b1;
          endcase
        end
        S1: begin
          state_d = IDLE;
          case (kind_q)
            K_CALL: uop_d = mk(C_BR, ALU_NOP, SP_NONE, MS_RSRC, PC_REG, 1'b0);
            K_RET:  uop_d = mk(C_BR, ALU_NOP, SP_NONE, MS_RSRC, PC_MEM, 1'b0);
            K_INT: begin
              if (SF) begin
                uop_d   = mk(C_MW, ALU_NOP, SP_PUSH, MS_FLAGS, PC_INC, 1'b0);
                state_d = S2;
              end else
                uop_d = mk(C_BR, ALU_NOP, SP_NONE, MS_RSRC, PC_VEC, 1'b0);
            end
            default: begin
              if (SF) begin
                uop_d   = mk(C_MR, ALU_NOP, SP_POP, MS_RSRC, PC_INC, 1'b0);
                state_d = S2;
              end else
                uop_d = mk(C_BR, ALU_NOP, SP_NONE, MS_RSRC, PC_MEM, 1'b0);
            end
          endcase
        end
        S2: begin
          state_d = IDLE;
          uop_d   = mk(C_BR, ALU_NOP, SP_NONE, MS_RSRC, (kind_q == K_INT) ? PC_VEC : PC_MEM, 1'b0);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      kind_q  <= K_CALL;
      uop_q   <= nop_uop();
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      uop_q   <= uop_d;
      ill_q   <= ill_d;
    end
  end

  assign in_ready   = (state_q == IDLE) & ~stall & rst_n;
  assign busy       = (state_q != IDLE);
  assign out_valid  = uop_q.vld;
  assign ctrl       = uop_q.ctrl;
  assign aluSignals = uop_q.alu;
  assign sp_op      = uop_q.sp_op;
  assign mem_src    = uop_q.mem_src;
  assign pc_sel     = uop_q.pc_sel;
  assign flags_load = uop_q.flags_load;
  assign illegal    = ill_q;

endmodule
